// File: rtl/rs232_des_pkg.sv
// Shared RS-232 definitions: FSM states, frame constants and the clogb2 helper
// used by both the serializer and the deserializer.
package rs232_des_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_SHIFT = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   localparam int DATA_BITS = 8;

   // Number of bits needed to hold 'value' itself (clogb2(16) = 5).
   function automatic int clogb2(input int value);
      int v;
      int n;
      v = value;
      n = 0;
      for (int i = 0; i < 32; i++) begin
         if (v > 0) begin
            n = n + 1;
            v = v >> 1;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/rs232_des_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable
// reset value so idle-high lines come out of reset at their idle level.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_reg <= RST_VAL;
         q        <= RST_VAL;
      end else begin
         meta_reg <= d;
         q        <= meta_reg;
      end
   end

endmodule

// File: rtl/rs232_des.sv
// RS-232 8N1 receiver: recovers bytes from the serial line by mid-bit sampling
// and writes good bytes to the RX FIFO, flagging framing errors and overruns.
module rs232_des
   import rs232_des_pkg::*;
#(
   parameter int P_CLK_FREQ_HZ = 100000000,
   parameter int P_BAUD_RATE   = 9600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_fifo_data,
   output logic       rx_fifo_wr_en,
   input  logic       rx_fifo_full,
   output logic       frame_err,
   output logic       overrun
);

   localparam int BIT_CNT  = P_CLK_FREQ_HZ / P_BAUD_RATE;
   localparam int HALF_CNT = BIT_CNT / 2;
   localparam int CNT_W    = clogb2(BIT_CNT);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT);
   localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

   logic             rx_s;
   logic             rx_d;
   state_t           state;
   logic [CNT_W-1:0] launch_cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       shift_reg;

   sync_2ff #(
      .RST_VAL(1'b1)
   ) u_rx_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (rx),
      .q    (rx_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_d          <= 1'b1;
         state         <= S_IDLE;
         launch_cnt    <= '0;
         bit_cnt       <= '0;
         shift_reg     <= '0;
         rx_fifo_data  <= '0;
         rx_fifo_wr_en <= 1'b0;
         frame_err     <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         rx_d          <= rx_s;
         rx_fifo_wr_en <= 1'b0;
         frame_err     <= 1'b0;
         overrun       <= 1'b0;

         case (state)
            S_IDLE: begin
               bit_cnt    <= '0;
               launch_cnt <= '0;
               // Edge-triggered so a held-low break cannot restart frames.
               if (rx_d && !rx_s) begin
                  state <= S_START;
               end
            end

            S_START: begin
               if (launch_cnt == HALF_LAST) begin
                  launch_cnt <= '0;
                  state      <= rx_s ? S_IDLE : S_SHIFT;
               end else begin
                  launch_cnt <= launch_cnt + CNT_W'(1);
               end
            end

            S_SHIFT: begin
               if (launch_cnt == BIT_LAST) begin
                  shift_reg  <= {rx_s, shift_reg[7:1]};
                  launch_cnt <= '0;
                  bit_cnt    <= bit_cnt + 3'd1;
                  if (bit_cnt == LAST_BIT) begin
                     state <= S_STOP;
                  end
               end else begin
                  launch_cnt <= launch_cnt + CNT_W'(1);
               end
            end

            S_STOP: begin
               if (launch_cnt == BIT_LAST) begin
                  launch_cnt <= '0;
                  state      <= S_IDLE;
                  // A bad stop bit wins over FIFO state: nothing is written.
                  if (!rx_s) begin
                     frame_err <= 1'b1;
                  end else if (rx_fifo_full) begin
                     overrun <= 1'b1;
                  end else begin
                     rx_fifo_data  <= shift_reg;
                     rx_fifo_wr_en <= 1'b1;
                  end
               end else begin
                  launch_cnt <= launch_cnt + CNT_W'(1);
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rs232_des.sv
// Randomized self-checking bench for rs232_des: frames are driven on rx and an
// event-queue model predicts each write / frame error / overrun and its cycle.
module tb_rs232_des;
   import rs232_des_pkg::*;

   localparam int BIT_P = 17;          // 1600 Hz / 100 baud -> 16 + 1 clocks
   localparam int LAT   = 166;         // rx fall edge -> edge that captures strobe

   localparam int K_WR = 1;
   localparam int K_FE = 2;
   localparam int K_OV = 3;

   typedef struct {
      int         kind;
      logic [7:0] data;
      int         edge_no;
   } ev_t;

   logic       clk;
   logic       rst_n;
   logic       rx;
   logic [7:0] rx_fifo_data;
   logic       rx_fifo_wr_en;
   logic       rx_fifo_full;
   logic       frame_err;
   logic       overrun;

   int         cyc = 0;
   int         n_checks = 0;
   int         n_errors = 0;
   ev_t        exp_q[$];
   logic [7:0] model_data = 8'h00;
   int         n_wr = 0;
   int         n_fe = 0;
   int         n_ov = 0;
   int         first_wr_cyc = -1;
   logic [7:0] first_wr_data = 8'h00;

   rs232_des #(
      .P_CLK_FREQ_HZ(1600),
      .P_BAUD_RATE  (100)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx           (rx),
      .rx_fifo_data (rx_fifo_data),
      .rx_fifo_wr_en(rx_fifo_wr_en),
      .rx_fifo_full (rx_fifo_full),
      .frame_err    (frame_err),
      .overrun      (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_errors = n_errors + 1;
         if (n_errors <= 25)
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Per-cycle compare against the event queue.
   initial begin
      logic exp_wr, exp_fe, exp_ov;
      forever begin
         @(negedge clk);
         exp_wr = 1'b0;
         exp_fe = 1'b0;
         exp_ov = 1'b0;
         if (exp_q.size() > 0 && exp_q[0].edge_no == cyc + 1) begin
            ev_t e;
            e = exp_q.pop_front();
            case (e.kind)
               K_WR: begin exp_wr = 1'b1; model_data = e.data; end
               K_FE: exp_fe = 1'b1;
               default: exp_ov = 1'b1;
            endcase
         end
         if (rx_fifo_wr_en) begin
            n_wr = n_wr + 1;
            if (first_wr_cyc < 0) begin
               first_wr_cyc  = cyc;
               first_wr_data = rx_fifo_data;
            end
         end
         if (frame_err) n_fe = n_fe + 1;
         if (overrun)   n_ov = n_ov + 1;
         check("wr_en", 32'(rx_fifo_wr_en), 32'(exp_wr));
         check("frame_err", 32'(frame_err), 32'(exp_fe));
         check("overrun", 32'(overrun), 32'(exp_ov));
         check("rx_fifo_data", 32'(rx_fifo_data), 32'(model_data));
      end
   end

   // Drives one 8N1 frame starting right after a clock edge. abort_bit >= 0
   // pulses rst_n in the middle of that data bit and abandons the frame.
   task automatic send_frame(input logic [7:0] data, input logic stop_val,
                             input logic full, input int abort_bit);
      ev_t e;
      $display("frame data=%02h stop=%0b full=%0b abort=%0d at cycle %0d",
               data, stop_val, full, abort_bit, cyc);
      if (abort_bit < 0) begin
         e.kind    = !stop_val ? K_FE : (full ? K_OV : K_WR);
         e.data    = data;
         e.edge_no = cyc + LAT;
         exp_q.push_back(e);
      end
      rx_fifo_full = full;
      rx = 1'b0;
      tick(BIT_P);
      for (int i = 0; i < 8; i++) begin
         rx = data[i];
         if (i == abort_bit) begin
            tick(8);
            #1;
            rst_n = 1'b0;
            model_data = 8'h00;
            #1;
            check("rst_wr_en", 32'(rx_fifo_wr_en), 32'd0);
            check("rst_frame_err", 32'(frame_err), 32'd0);
            check("rst_overrun", 32'(overrun), 32'd0);
            check("rst_data", 32'(rx_fifo_data), 32'd0);
            check("rst_state", 32'(dut.state), 32'(S_IDLE));
            rx = 1'b1;
            rx_fifo_full = 1'b0;
            tick(3);
            rst_n = 1'b1;
            return;
         end
         tick(BIT_P);
      end
      rx = stop_val;
      tick(BIT_P);
      rx_fifo_full = 1'b0;
   endtask

   task automatic glitch(input int len);
      $display("glitch len=%0d at cycle %0d", len, cyc);
      rx = 1'b0;
      tick(len);
      rx = 1'b1;
      tick(20);
   endtask

   initial begin
      int fall0;
      rst_n = 1'b0;
      rx = 1'b1;
      rx_fifo_full = 1'b0;
      #2;
      check("reset_wr_en", 32'(rx_fifo_wr_en), 32'd0);
      check("reset_data", 32'(rx_fifo_data), 32'd0);
      check("reset_frame_err", 32'(frame_err), 32'd0);
      check("reset_overrun", 32'(overrun), 32'd0);
      check("reset_state", 32'(dut.state), 32'(S_IDLE));
      tick(3);
      rst_n = 1'b1;
      tick(10);

      // 0xA5: strobe captured at t0+163, t0 three edges after the pin falls.
      fall0 = cyc;
      send_frame(8'hA5, 1'b1, 1'b0, -1);
      tick(10);
      check("a5_latency", 32'(first_wr_cyc + 1 - fall0), 32'd166);
      check("a5_data", 32'(first_wr_data), 32'h000000A5);

      // back-to-back, no idle gap
      send_frame(8'h00, 1'b1, 1'b0, -1);
      send_frame(8'hFF, 1'b1, 1'b0, -1);
      send_frame(8'h3C, 1'b1, 1'b0, -1);
      tick(5);

      glitch(5);
      send_frame(8'h81, 1'b1, 1'b0, -1);
      tick(5);

      // bad stop bit, then a 40-bit break
      send_frame(8'h55, 1'b0, 1'b0, -1);
      tick(40 * BIT_P);
      rx = 1'b1;
      tick(BIT_P);
      send_frame(8'h12, 1'b1, 1'b0, -1);
      tick(5);

      send_frame(8'h77, 1'b1, 1'b1, -1);
      tick(5);
      check("overrun_keeps_data", 32'(rx_fifo_data), 32'h00000012);
      send_frame(8'h78, 1'b1, 1'b0, -1);
      tick(5);
      check("directed_writes", 32'(n_wr), 32'd7);
      check("directed_frame_errs", 32'(n_fe), 32'd1);
      check("directed_overruns", 32'(n_ov), 32'd1);

      send_frame(8'hC3, 1'b1, 1'b0, 4);
      tick(40);
      send_frame(8'h5A, 1'b1, 1'b0, -1);
      tick(5);
      check("after_reset_data", 32'(rx_fifo_data), 32'h0000005A);

      for (int n = 0; n < 30; n++) begin
         logic [7:0] d;
         logic       stop_v;
         logic       full_v;
         d      = 8'($urandom);
         stop_v = ($urandom_range(0, 7) != 0);
         full_v = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 5) == 0)
            glitch($urandom_range(1, 6));
         send_frame(d, stop_v, full_v, -1);
         if (!stop_v) begin
            rx = 1'b1;
            tick(BIT_P);
         end
         tick($urandom_range(0, 20));
      end

      tick(200);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
